// File: rtl/student_fir_out_buffer.sv
// Stereo elastic buffer between the FIR output and the IIS transmitter.
// Accepts FIR result pairs over valid/ready, stores up to DEPTH pairs and
// releases one pair per audio frame request, with a fallback pair on underflow.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   fir_valid_i / fir_ready_o      FIR pair handshake (ready = level != DEPTH)
//   fir_data_l_i / fir_data_r_i    FIR left/right samples
//   frame_req_i                    one-cycle request per audio frame
//   hold_last_i                    underflow policy: 1 repeat last pair, 0 zeros
//   flush_i                        synchronous flush of the FIFO contents
//   iis_data_l_o / iis_data_r_o    registered samples to the transmitter
//   iis_valid_o                    one-cycle strobe per served request
//   level_o                        FIFO occupancy
//   underflow_cnt_o, drop_cnt_o    saturating event counters
module student_fir_out_buffer #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         fir_valid_i,
    output logic                         fir_ready_o,
    input  logic [DATA_SIZE-1:0]         fir_data_l_i,
    input  logic [DATA_SIZE-1:0]         fir_data_r_i,
    input  logic                         frame_req_i,
    input  logic                         hold_last_i,
    input  logic                         flush_i,
    output logic [DATA_SIZE-1:0]         iis_data_l_o,
    output logic [DATA_SIZE-1:0]         iis_data_r_o,
    output logic                         iis_valid_o,
    output logic [$clog2(DEPTH):0]       level_o,
    output logic [CNT_WIDTH-1:0]         underflow_cnt_o,
    output logic [CNT_WIDTH-1:0]         drop_cnt_o
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
    localparam int unsigned PAIR_W = 2 * DATA_SIZE;

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [PAIR_W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [DATA_SIZE-1:0]   out_l_q, out_l_d;
    logic [DATA_SIZE-1:0]   out_r_q, out_r_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   ucnt_q, ucnt_d;
    logic [CNT_WIDTH-1:0]   dcnt_q, dcnt_d;
    logic                   push, pop, underflow, drop, empty;

    assign fir_ready_o     = (level_q != LVL_W'(DEPTH));
    assign empty           = (level_q == '0);
    assign iis_data_l_o    = out_l_q;
    assign iis_data_r_o    = out_r_q;
    assign iis_valid_o     = valid_q;
    assign level_o         = level_q;
    assign underflow_cnt_o = ucnt_q;
    assign drop_cnt_o      = dcnt_q;

    // Next-state: FSM, pointers, level, output pair and counters
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        valid_d   = frame_req_i;
        ucnt_d    = ucnt_q;
        dcnt_d    = dcnt_q;
        push      = 1'b0;
        pop       = 1'b0;
        underflow = 1'b0;
        drop      = fir_valid_i & ~fir_ready_o;

        if (flush_i) begin
            state_d = ST_PRIME;
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            push      = fir_valid_i & fir_ready_o;
            // An empty pop is an underflow even if a push lands this cycle
            pop       = frame_req_i & (state_q == ST_RUN) & ~empty;
            underflow = frame_req_i & (state_q == ST_RUN) & empty;

            if (push) wptr_d = wptr_q + PTR_W'(1);
            if (pop)  rptr_d = rptr_q + PTR_W'(1);

            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            case (state_q)
                ST_PRIME: if (level_q >= LVL_W'(DEPTH / 2)) state_d = ST_RUN;
                ST_RUN:   if (underflow) state_d = ST_PRIME;
                default:  state_d = ST_PRIME;
            endcase
        end

        // Fallback pair: hold keeps the output registers as they are
        if (frame_req_i) begin
            if (pop) begin
                out_l_d = mem_q[rptr_q][PAIR_W-1:DATA_SIZE];
                out_r_d = mem_q[rptr_q][DATA_SIZE-1:0];
            end else if (!hold_last_i) begin
                out_l_d = '0;
                out_r_d = '0;
            end
        end

        if (underflow && (ucnt_q != '1)) ucnt_d = ucnt_q + CNT_WIDTH'(1);
        if (drop && (dcnt_q != '1))      dcnt_d = dcnt_q + CNT_WIDTH'(1);
    end

    // State and control registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_PRIME;
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            out_l_q <= '0;
            out_r_q <= '0;
            valid_q <= 1'b0;
            ucnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            out_l_q <= out_l_d;
            out_r_q <= out_r_d;
            valid_q <= valid_d;
            ucnt_q  <= ucnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Pair storage; contents are only meaningful below level, so no reset
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= {fir_data_l_i, fir_data_r_i};
    end

endmodule

// File: doc/student_fir_out_buffer.md
# student_fir_out_buffer

Stereo elastic buffer between the parallel FIR filter output and the IIS handler transmit input. Accepts FIR result pairs over a valid/ready handshake, stores them in a DEPTH-entry FIFO and releases exactly one stereo pair per audio frame request. This absorbs the jitter between FIR completion and codec frame timing, and applies a defined fallback sample on underflow.

## Interface
Parameters:
- DATA_SIZE, 16, sample width per channel, signed two's complement.
- DEPTH, 4, FIFO entries (stereo pairs); power of two, ≥ 2.
- CNT_WIDTH, 8, width of the saturating event counters.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- fir_valid_i  in  1  FIR result pair valid.
- fir_ready_o  out  1  buffer can accept a pair; equals (level != DEPTH), combinational from registered level.
- fir_data_l_i  in  DATA_SIZE  left FIR result.
- fir_data_r_i  in  DATA_SIZE  right FIR result.
- frame_req_i  in  1  one-cycle pulse per audio frame (IIS handler sample strobe).
- hold_last_i  in  1  underflow policy: 1 = repeat last emitted pair, 0 = emit zeros.
- flush_i  in  1  synchronous flush pulse.
- iis_data_l_o  out  DATA_SIZE  left sample to transmitter, registered.
- iis_data_r_o  out  DATA_SIZE  right sample to transmitter, registered.
- iis_valid_o  out  1  one-cycle strobe, data valid.
- level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
- underflow_cnt_o  out  CNT_WIDTH  RUN-state frame requests served with the fallback pair.
- drop_cnt_o  out  CNT_WIDTH  pairs offered while full (fir_valid_i & !fir_ready_o).

## Operation
- Storage: DEPTH×(2·DATA_SIZE) register array. Write and read pointers wrap modulo DEPTH. Level is held in a separate counter, 0..DEPTH.
- Push: fir_valid_i & fir_ready_o writes {L,R} at wptr, then wptr+1.
- Drop: fir_valid_i while full leaves the FIFO unchanged and increments drop_cnt_o.
- State machine: PRIME, RUN. Reset and flush enter PRIME.
- PRIME:
  - frame_req_i emits the fallback pair without popping and without counting underflow.
  - Go to RUN when level ≥ DEPTH/2, evaluated on the registered level at each clock edge.
- RUN, on frame_req_i:
  - level > 0: pop the pair at rptr, then rptr+1.
  - level == 0: emit the fallback pair, increment underflow_cnt_o, go to PRIME.
- Fallback pair: last emitted iis_data_l/r_o when hold_last_i=1; 0/0 when hold_last_i=0.
- Simultaneous push and pop: both take effect and level is unchanged. When full, ready is low, so no push occurs; the pop still frees an entry for the next cycle. An empty pop is never bypassed by a same-cycle push: it is an underflow, and the push is stored.
- flush_i: pointers and level reset to 0, state goes to PRIME, same-cycle push and pop are ignored. Outputs and counters are kept.
- Counters saturate at 2^CNT_WIDTH−1 and clear only on reset.
- Data passes through bit-exact; no arithmetic on samples.

## Timing
- Reset values: iis_data_l_o=0, iis_data_r_o=0, iis_valid_o=0, level_o=0, underflow_cnt_o=0, drop_cnt_o=0, fir_ready_o=1, state PRIME, pointers 0.
- frame_req_i at edge N gives iis_data_*_o and iis_valid_o valid after edge N (1-cycle latency). iis_valid_o is high for exactly one cycle per request.
- A push accepted at edge N is visible in level_o after N and is poppable by a frame_req_i at edge N+1 or later.
- A PRIME→RUN transition seen at edge N applies to a frame_req_i at edge N+1.
- Reset asserted mid-operation clears everything asynchronously; buffered pairs are lost.
- frame_req_i pulses closer than 1 cycle apart do not occur; back-to-back pulses on consecutive cycles are legal, each served.

## Test plan
- Prime, DEPTH=4, hold_last_i=0: push 0x0101/0x0202 then 0x0303/0x0404, then frame_req -> first request in PRIME before the 2nd push gives 0/0; after 2 pushes, the next request gives 0x0101/0x0202, level_o=1.
- Fill and drop: 5 pushes with no requests -> level_o=4, fir_ready_o=0, drop_cnt_o=1; drain with 4 requests -> the 4 stored pairs emerge in order and fir_ready_o returns to 1.
- Underflow with hold: RUN, last output 0x7FFF/0x8000, level 0, hold_last_i=1, frame_req -> 0x7FFF/0x8000, underflow_cnt_o=1, state PRIME.
- Simultaneous push and pop at level 2 -> level_o stays 2, oldest pair emitted, new pair stored at the wrapped wptr. Repeat ≥ 3·DEPTH times to check pointer wrap.
- Flush at level 3 with a same-cycle push -> level_o=0, pushed pair discarded, next frame_req emits fallback with underflow_cnt_o unchanged.
- Counter saturation (CNT_WIDTH=8): 300 forced drops -> drop_cnt_o=255. Async reset mid-stream -> all outputs return to reset values immediately.
